// File: rtl/line_sched.sv
// line_sched: walks a rectangular tile line by line and issues one command per
// line to the buffer line-read controller (inlinecontrol). A new command is only
// issued once the controller has dropped ready, because a valid during an
// active line would restart that line.
// Optional feature: define LINE_SCHED_STALL_CNT_EN to add the stall_cnt output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; rejects bad configurations
// S_ISSUE | valid is high this cycle with the current line's command
// S_WAIT  | controller working on the line; advance on first ready low
// S_DRAIN | last line handed off; counting down the output pipeline
module line_sched #(
  parameter int X_MAC        = 4,
  parameter int ADDR_LEN     = 13,
  parameter int MAX_LINE_LEN = 10,
  parameter int LINE_CNT_LEN = 10,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_LEN-1:0]       cfg_base_addr,
  input  logic [ADDR_LEN-1:0]       cfg_mac_stride,
  input  logic [ADDR_LEN-1:0]       cfg_line_stride,
  input  logic [MAX_LINE_LEN-1:0]   cfg_linelen,
  input  logic [LINE_CNT_LEN-1:0]   cfg_num_lines,
  input  logic                      cfg_ispad,
  input  logic                      cfg_chain_en,
  input  logic                      ctrl_ready,
  output logic [ADDR_LEN*X_MAC-1:0] st_addr,
  output logic [MAX_LINE_LEN-1:0]   linelen,
  output logic                      ispad,
  output logic                      valid,
  output logic                      tofifo,
  output logic                      fromfifo,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
`ifdef LINE_SCHED_STALL_CNT_EN
  , output logic [15:0]             stall_cnt
`endif
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t                    state;
  logic [ADDR_LEN*X_MAC-1:0] lane_off;
  logic [ADDR_LEN-1:0]       line_base;
  logic [ADDR_LEN-1:0]       line_stride;
  logic [LINE_CNT_LEN-1:0]   line_idx;
  logic [LINE_CNT_LEN-1:0]   last_idx;
  logic                      chain_en;
  logic [DRAIN_W-1:0]        drain_cnt;

  logic [ADDR_LEN-1:0]       acc;
  logic [ADDR_LEN*X_MAC-1:0] start_off;
  logic [ADDR_LEN*X_MAC-1:0] start_addr;
  logic [ADDR_LEN*X_MAC-1:0] next_addr;
  logic [ADDR_LEN-1:0]       next_base;
  logic [LINE_CNT_LEN-1:0]   next_idx;

  // Lane offsets are a running sum of the MAC stride (no multiplier); the sum
  // is only captured at start, later lines reuse the stored offsets.
  always_comb begin
    acc        = '0;
    start_off  = '0;
    start_addr = '0;
    next_addr  = '0;
    next_base  = line_base + line_stride;
    next_idx   = line_idx + 1'b1;
    for (int j = 0; j < X_MAC; j++) begin
      start_off[j*ADDR_LEN +: ADDR_LEN]  = acc;
      start_addr[j*ADDR_LEN +: ADDR_LEN] = cfg_base_addr + acc;
      next_addr[j*ADDR_LEN +: ADDR_LEN]  = next_base + lane_off[j*ADDR_LEN +: ADDR_LEN];
      acc = acc + cfg_mac_stride;
    end
  end

  // Scheduler FSM with all outputs registered; abort overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      valid       <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      st_addr     <= '0;
      linelen     <= '0;
      ispad       <= 1'b0;
      tofifo      <= 1'b0;
      fromfifo    <= 1'b0;
      lane_off    <= '0;
      line_base   <= '0;
      line_stride <= '0;
      line_idx    <= '0;
      last_idx    <= '0;
      chain_en    <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      valid   <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        line_idx  <= '0;
        drain_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              lane_off    <= start_off;
              line_base   <= cfg_base_addr;
              line_stride <= cfg_line_stride;
              line_idx    <= '0;
              last_idx    <= cfg_num_lines - 1'b1;
              chain_en    <= cfg_chain_en;
              if (cfg_linelen < MAX_LINE_LEN'(4)) begin
                cfg_err <= 1'b1;
                done    <= 1'b1;
              end else if (cfg_num_lines == '0) begin
                done <= 1'b1;
              end else begin
                state    <= S_ISSUE;
                busy     <= 1'b1;
                valid    <= 1'b1;
                st_addr  <= start_addr;
                linelen  <= cfg_linelen;
                ispad    <= cfg_ispad;
                tofifo   <= cfg_chain_en && (cfg_num_lines != LINE_CNT_LEN'(1));
                fromfifo <= 1'b0;
              end
            end
          end
          S_ISSUE: state <= S_WAIT;
          S_WAIT: begin
            // first cycle with ready low means the controller finished the line
            if (!ctrl_ready) begin
              line_idx  <= next_idx;
              line_base <= next_base;
              if (line_idx == last_idx) begin
                state     <= S_DRAIN;
                drain_cnt <= DRAIN_LOAD;
              end else begin
                state    <= S_ISSUE;
                valid    <= 1'b1;
                st_addr  <= next_addr;
                tofifo   <= chain_en && (next_idx != last_idx);
                fromfifo <= chain_en;
              end
            end
          end
          S_DRAIN: begin
            if (drain_cnt == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LINE_SCHED_STALL_CNT_EN
  // Saturating count of WAIT cycles in which the controller is still busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!abort) begin
      if (state == S_IDLE && start) begin
        stall_cnt <= '0;
      end else if (state == S_WAIT && ctrl_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_sched.sv
`timescale 1ns/1ps
module tb_line_sched;
  localparam int X_MAC = 4;
  localparam int AL    = 13;
  localparam int LL    = 10;
  localparam int LC    = 10;

  typedef struct packed {
    logic [AL*X_MAC-1:0] addr;
    logic                tof;
    logic                fromf;
    logic [LL-1:0]       len;
    logic                pad;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort;
  logic [AL-1:0]     cfg_base_addr, cfg_mac_stride, cfg_line_stride;
  logic [LL-1:0]     cfg_linelen;
  logic [LC-1:0]     cfg_num_lines;
  logic              cfg_ispad, cfg_chain_en;
  logic              ctrl_ready;
  logic [AL*X_MAC-1:0] st_addr;
  logic [LL-1:0]     linelen;
  logic              ispad, valid, tofifo, fromfifo, busy, done, cfg_err;
`ifdef LINE_SCHED_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_seen = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int ready_hold = 3;
  logic prev_ready = 1'b0;
  cmd_t exp_q[$];
  cmd_t exp_c, got_c;

  line_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_mac_stride(cfg_mac_stride),
    .cfg_line_stride(cfg_line_stride), .cfg_linelen(cfg_linelen),
    .cfg_num_lines(cfg_num_lines), .cfg_ispad(cfg_ispad),
    .cfg_chain_en(cfg_chain_en), .ctrl_ready(ctrl_ready),
    .st_addr(st_addr), .linelen(linelen), .ispad(ispad), .valid(valid),
    .tofifo(tofifo), .fromfifo(fromfifo), .busy(busy), .done(done),
    .cfg_err(cfg_err)
`ifdef LINE_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // controller model: ready rises the cycle after valid, stays high ready_hold cycles
  initial begin
    ctrl_ready = 1'b0;
    forever begin
      @(posedge clk);
      if (valid === 1'b1) begin
        #1 ctrl_ready = 1'b1;
        repeat (ready_hold) @(posedge clk);
        #1 ctrl_ready = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid got st_addr=%h with no command expected", st_addr);
      end else begin
        exp_c = exp_q.pop_front();
        got_c = {st_addr, tofifo, fromfifo, linelen, ispad};
        if (got_c !== exp_c) begin
          failures++;
          $display("FAIL cmd got=%h exp=%h", got_c, exp_c);
        end
      end
    end
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (cfg_err === 1'b1) err_cnt++;
    if (prev_ready && !ctrl_ready) fall_cyc = cyc;
    prev_ready = ctrl_ready;
  end

  task automatic push_tile(input logic [AL-1:0] b, input logic [AL-1:0] ms,
                           input logic [AL-1:0] ls, input logic [LL-1:0] len,
                           input int n, input logic pad, input logic chain);
    cmd_t c;
    logic [31:0] sum;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < X_MAC; j++) begin
        sum = 32'(b) + 32'(i) * 32'(ls) + 32'(j) * 32'(ms);
        c.addr[j*AL +: AL] = sum[AL-1:0];
      end
      c.tof   = chain && (i != n - 1);
      c.fromf = chain && (i != 0);
      c.len   = len;
      c.pad   = pad;
      exp_q.push_back(c);
    end
  endtask

  task automatic start_tile(input logic [AL-1:0] b, input logic [AL-1:0] ms,
                            input logic [AL-1:0] ls, input logic [LL-1:0] len,
                            input int n, input logic pad, input logic chain);
    @(posedge clk); #1;
    cfg_base_addr = b; cfg_mac_stride = ms; cfg_line_stride = ls;
    cfg_linelen = len; cfg_num_lines = LC'(n); cfg_ispad = pad; cfg_chain_en = chain;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base_done, input int max_cyc, input string name);
    int n = 0;
    while (done_cnt == base_done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == base_done) begin
      failures++;
      $display("FAIL %s_timeout no done within %0d cycles", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0;
    cfg_base_addr = '0; cfg_mac_stride = '0; cfg_line_stride = '0;
    cfg_linelen = '0; cfg_num_lines = '0; cfg_ispad = 0; cfg_chain_en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid, done, busy, cfg_err, tofifo, fromfifo, ispad} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {valid, done, busy, cfg_err, tofifo, fromfifo, ispad});
    end
    checks++;
    if ({st_addr, linelen} !== '0) begin
      failures++;
      $display("FAIL reset_cmd got=%h exp=0", {st_addr, linelen});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int d0, v0;
    d0 = done_cnt; v0 = valid_seen;
    ready_hold = 3;
    push_tile(13'h010, 13'h100, 13'h020, 10'd8, 3, 1'b0, 1'b1);
    start_tile(13'h010, 13'h100, 13'h020, 10'd8, 3, 1'b0, 1'b1);
    wait_done(d0, 200, "basic");
    checks++;
    if (valid_seen - v0 != 3) begin
      failures++; $display("FAIL basic_count got=%0d exp=3", valid_seen - v0);
    end
    checks++;
    if (done_cyc - fall_cyc != 6) begin
      failures++; $display("FAIL basic_drain got=%0d exp=6", done_cyc - fall_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL basic_busy got=%b exp=0", busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL basic_done_once got=%0d exp=1 left=%0d", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int d0;
    d0 = done_cnt;
    push_tile(13'h1FF0, 13'h008, 13'h020, 10'd16, 2, 1'b1, 1'b0);
    start_tile(13'h1FF0, 13'h008, 13'h020, 10'd16, 2, 1'b1, 1'b0);
    wait_done(d0, 200, "wrap");
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL wrap_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_cfg_err();
    int v0, e0, d0;
    v0 = valid_seen; e0 = err_cnt; d0 = done_cnt;
    start_tile(13'h000, 13'h010, 13'h010, 10'd3, 2, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({cfg_err, done, valid, busy} !== 4'b1100) begin
      failures++; $display("FAIL cfg_err_pulse got=%b exp=1100", {cfg_err, done, valid, busy});
    end
    start_tile(13'h000, 13'h010, 13'h010, 10'd8, 0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if ({cfg_err, done, valid, busy} !== 4'b0100) begin
      failures++; $display("FAIL zero_lines_pulse got=%b exp=0100", {cfg_err, done, valid, busy});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (valid_seen != v0 || err_cnt - e0 != 1 || done_cnt - d0 != 2) begin
      failures++;
      $display("FAIL cfg_err_totals got valid=%0d err=%0d done=%0d exp 0 1 2",
               valid_seen - v0, err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int v0, d0, n;
    ready_hold = 4;
    v0 = valid_seen; d0 = done_cnt;
    push_tile(13'h100, 13'h040, 13'h200, 10'd12, 4, 1'b0, 1'b1);
    start_tile(13'h100, 13'h040, 13'h200, 10'd12, 4, 1'b0, 1'b1);
    n = 0;
    while (valid_seen - v0 < 2 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (valid_seen - v0 < 2) begin
      failures++; $display("FAIL abort_reach got=%0d exp=2", valid_seen - v0);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, valid, done} !== 3'b000) begin
      failures++; $display("FAIL abort_idle got=%b exp=000", {busy, valid, done});
    end
    exp_q.delete();
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt != d0 || valid_seen - v0 != 2) begin
      failures++;
      $display("FAIL abort_quiet got done=%0d valid=%0d exp 0 2", done_cnt - d0, valid_seen - v0);
    end
    v0 = valid_seen;
    push_tile(13'h100, 13'h040, 13'h200, 10'd12, 4, 1'b0, 1'b1);
    start_tile(13'h100, 13'h040, 13'h200, 10'd12, 4, 1'b0, 1'b1);
    wait_done(d0, 300, "abort_restart");
    checks++;
    if (valid_seen - v0 != 4) begin
      failures++; $display("FAIL abort_restart_count got=%0d exp=4", valid_seen - v0);
    end
    ready_hold = 3;
  endtask

  task automatic test_start_ignored();
    int v0, d0;
    v0 = valid_seen; d0 = done_cnt;
    push_tile(13'h020, 13'h004, 13'h040, 10'd9, 2, 1'b1, 1'b1);
    start_tile(13'h020, 13'h004, 13'h040, 10'd9, 2, 1'b1, 1'b1);
    @(posedge clk); #1;
    cfg_base_addr = 13'h0AAA; cfg_num_lines = 10'd5; cfg_linelen = 10'd20;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, 200, "ignored");
    repeat (20) @(negedge clk);
    checks++;
    if (valid_seen - v0 != 2 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL ignored_start got valid=%0d done=%0d exp 2 1", valid_seen - v0, done_cnt - d0);
    end
  endtask

  task automatic test_rst_mid();
    int d0;
    d0 = done_cnt;
    start_tile(13'h055, 13'h011, 13'h022, 10'd8, 3, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid, busy, done, cfg_err, tofifo, fromfifo, ispad} !== 7'b0 || {st_addr, linelen} !== '0) begin
      failures++;
      $display("FAIL rst_mid got flags=%b cmd=%h exp 0", {valid, busy, done, cfg_err, tofifo, fromfifo, ispad},
               {st_addr, linelen});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      failures++; $display("FAIL rst_mid_done got=%0d exp=0", done_cnt - d0);
    end
  endtask

`ifdef LINE_SCHED_STALL_CNT_EN
  task automatic test_stall_cnt();
    int d0;
    d0 = done_cnt;
    ready_hold = 3;
    push_tile(13'h000, 13'h001, 13'h010, 10'd8, 2, 1'b0, 1'b0);
    start_tile(13'h000, 13'h001, 13'h010, 10'd8, 2, 1'b0, 1'b0);
    wait_done(d0, 200, "stall");
    repeat (4) @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd6) begin
      failures++; $display("FAIL stall_cnt got=%0d exp=6", stall_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_cfg_err();
    test_abort();
    test_start_ignored();
    test_rst_mid();
`ifdef LINE_SCHED_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
